// File: rtl/fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// fetch_queue_pkg
// Entry type and packing helper shared by the fetch queue and its users.
// Revision: 1.0
//------------------------------------------------------------------------------
`include "sysconfig.v"
`default_nettype none

package fetch_queue_pkg;
   localparam int TRAP_LEN             = `TRAP_LEN;
   localparam int ENTRY_W              = `FQ_ENTRY_W;
   localparam int TRAP_INST_PAGE_FAULT = `TRAP_INST_PAGE_FAULT;

   typedef logic [ENTRY_W-1:0] fq_entry_t;

   function automatic fq_entry_t fq_pack(input logic [31:0]         pc,
                                         input logic [31:0]         inst,
                                         input logic [TRAP_LEN-1:0] trap,
                                         input logic                cmp);
      fq_entry_t e;
      e                 = '0;
      e[`FQ_PC_RANGE]   = pc;
      e[`FQ_INST_RANGE] = inst;
      e[`FQ_CMP_BIT]    = cmp;
      e[`FQ_TRAP_RANGE] = trap;
      return e;
   endfunction
endpackage

`default_nettype wire

// File: rtl/sysconfig.v
//------------------------------------------------------------------------------
// sysconfig.v
// Shared trap-bus width, trap cause bits and fetch-queue entry layout.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`ifndef SYSCONFIG_V
`define SYSCONFIG_V

`define TRAP_LEN                 4
`define TRAP_BUS                 [`TRAP_LEN-1:0]
`define TRAP_INST_ADDR_MISALIGN  0
`define TRAP_INST_ACCESS_FAULT   1
`define TRAP_ILLEGAL_INST        2
`define TRAP_INST_PAGE_FAULT     3

// Packed entry: {trap, cmp, inst, pc}
`define FQ_ENTRY_W               (65+`TRAP_LEN)
`define FQ_PC_RANGE              31:0
`define FQ_INST_RANGE            63:32
`define FQ_CMP_BIT               64
`define FQ_TRAP_RANGE            (65+`TRAP_LEN-1):65

`endif
`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// fetch_queue
// Registered FIFO between ifu and decode; no bypass, flush clears all entries.
// Revision: 1.0
//------------------------------------------------------------------------------
`include "sysconfig.v"
`default_nettype none

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [31:0]         in_pc_i,
   input  logic [31:0]         in_inst_i,
   input  logic `TRAP_BUS      in_trap_i,
   input  logic                in_cmp_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [31:0]         out_pc_o,
   output logic [31:0]         out_inst_o,
   output logic `TRAP_BUS      out_trap_o,
   output logic                out_cmp_o,
   input  logic                flush_i,
   output logic [PTR_W:0]      count_o
);

   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   fq_entry_t        mem_q [DEPTH];
   fq_entry_t        mem_d [DEPTH];
   fq_entry_t        head;
   logic             push;
   logic             pop;

   // Handshakes come from registered occupancy only, never from flush_i.
   assign in_ready_o  = (count_q < DEPTH_CNT);
   assign out_valid_o = (count_q != '0);
   assign count_o     = count_q;

   assign head        = mem_q[rd_ptr_q];
   assign out_pc_o    = head[`FQ_PC_RANGE];
   assign out_inst_o  = head[`FQ_INST_RANGE];
   assign out_cmp_o   = head[`FQ_CMP_BIT];
   assign out_trap_o  = head[`FQ_TRAP_RANGE];

   always_comb begin
      push     = in_valid_i && in_ready_o && !flush_i;
      pop      = out_valid_o && out_ready_i && !flush_i;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = fq_pack(in_pc_i, in_inst_i, in_trap_i, in_cmp_i);
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   // Underflow wraps the unsigned count above DEPTH, so one bound covers both.
   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                   count_q <= DEPTH_CNT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// tb_fetch_queue
// Vector table plus scoreboard bench for fetch_queue.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [31:0]         in_pc_i;
   logic [31:0]         in_inst_i;
   logic [TRAP_LEN-1:0] in_trap_i;
   logic                in_cmp_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [31:0]         out_pc_o;
   logic [31:0]         out_inst_o;
   logic [TRAP_LEN-1:0] out_trap_o;
   logic                out_cmp_o;
   logic                flush_i;
   logic [PTR_W:0]      count_o;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_pc_i     (in_pc_i),
      .in_inst_i   (in_inst_i),
      .in_trap_i   (in_trap_i),
      .in_cmp_i    (in_cmp_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_pc_o    (out_pc_o),
      .out_inst_o  (out_inst_o),
      .out_trap_o  (out_trap_o),
      .out_cmp_o   (out_cmp_o),
      .flush_i     (flush_i),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                v;
      logic                r;
      logic                f;
      logic [31:0]         pc;
      logic [31:0]         inst;
      logic [TRAP_LEN-1:0] trap;
      logic                cmp;
      int                  ec;
   } vec_t;

   typedef struct {
      logic [31:0]         pc;
      logic [31:0]         inst;
      logic [TRAP_LEN-1:0] trap;
      logic                cmp;
   } ent_t;

   vec_t tbl[$];
   ent_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void add(input logic v, input logic r, input logic f,
                               input logic [31:0] pc, input logic [TRAP_LEN-1:0] trap,
                               input int ec);
      vec_t t;
      t.v = v; t.r = r; t.f = f; t.pc = pc;
      t.inst = ~pc ^ 32'h0000_0013;
      t.trap = trap; t.cmp = pc[2]; t.ec = ec;
      tbl.push_back(t);
   endfunction

   // One cycle: drive, check pre-edge state against ec, score the handshakes.
   task automatic step(input vec_t t, input logic rn);
      ent_t e;
      logic do_push, do_pop;
      in_valid_i  = t.v;
      out_ready_i = t.r;
      flush_i     = t.f;
      in_pc_i     = t.pc;
      in_inst_i   = t.inst;
      in_trap_i   = t.trap;
      in_cmp_i    = t.cmp;
      rst_n       = rn;
      #1;
      chk("count", 32'(count_o), 32'(t.ec));
      chk("out_valid", 32'(out_valid_o), 32'(t.ec != 0));
      chk("in_ready", 32'(in_ready_o), 32'(t.ec < DEPTH));
      do_pop  = rn && !t.f && t.r && (t.ec != 0);
      do_push = rn && !t.f && t.v && (t.ec < DEPTH);
      if (do_pop) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underrun actual=pop required=empty");
         end else begin
            e = sb.pop_front();
            chk("head_pc", out_pc_o, e.pc);
            chk("head_inst", out_inst_o, e.inst);
            chk("head_trap", 32'(out_trap_o), 32'(e.trap));
            chk("head_cmp", 32'(out_cmp_o), 32'(e.cmp));
         end
      end
      if (do_push) begin
         e.pc = t.pc; e.inst = t.inst; e.trap = t.trap; e.cmp = t.cmp;
         sb.push_back(e);
      end
      if (!rn || t.f) sb.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [TRAP_LEN-1:0] pf;
      vec_t t;
      pf = '0;
      pf[TRAP_INST_PAGE_FAULT] = 1'b1;

      // Single push, visible next cycle.
      add(1, 0, 0, 32'h8000_0000, '0, 0);
      add(0, 1, 0, 32'h0, '0, 1);
      // Fill to full, blocked 5th offer, full push+pop is pop only, drain.
      for (int i = 0; i < 4; i++) add(1, 0, 0, 32'h40 + 32'(4*i), '0, i);
      add(1, 0, 0, 32'hDEAD_0000, '0, 4);
      add(1, 1, 0, 32'hBAD0_0000, '0, 4);
      add(0, 0, 0, 32'h0, '0, 3);
      for (int i = 3; i > 0; i--) add(0, 1, 0, 32'h0, '0, i);
      // Steady push+pop at count 2 with pointer wrap.
      add(1, 0, 0, 32'h100, '0, 0);
      add(1, 0, 0, 32'h104, '0, 1);
      for (int i = 0; i < 10; i++) add(1, 1, 0, 32'h108 + 32'(4*i), '0, 2);
      add(0, 1, 0, 32'h0, '0, 2);
      add(0, 1, 0, 32'h0, '0, 1);
      // Trap entry then normal entry.
      add(1, 0, 0, 32'h300, pf, 0);
      add(1, 0, 0, 32'h304, '0, 1);
      add(0, 1, 0, 32'h0, '0, 2);
      add(0, 1, 0, 32'h0, '0, 1);
      // Flush at count 3 with push and pop offered.
      for (int i = 0; i < 3; i++) add(1, 0, 0, 32'h400 + 32'(4*i), '0, i);
      add(1, 1, 1, 32'h40C, '0, 3);
      add(0, 1, 0, 32'h0, '0, 0);
      // Queue still works after flush.
      add(1, 0, 0, 32'h500, pf, 0);
      add(0, 1, 0, 32'h0, '0, 1);

      in_valid_i = 0; out_ready_i = 0; flush_i = 0;
      in_pc_i = '0; in_inst_i = '0; in_trap_i = '0; in_cmp_i = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count_o), 0);
      chk("rst_valid", 32'(out_valid_o), 0);
      chk("rst_ready", 32'(in_ready_o), 1);
      chk("rst_head_pc", out_pc_o, 0);
      chk("rst_head_inst", out_inst_o, 0);
      chk("rst_head_trap", 32'(out_trap_o), 0);
      chk("rst_head_cmp", 32'(out_cmp_o), 0);

      foreach (tbl[i]) step(tbl[i], 1'b1);

      // Mid-operation reset at count 2 overrides push and pop.
      t.v = 1; t.r = 0; t.f = 0; t.trap = '0; t.cmp = 1; t.inst = 32'h1234_5677;
      t.pc = 32'h600; t.ec = 0; step(t, 1'b1);
      t.pc = 32'h604; t.ec = 1; step(t, 1'b1);
      t.pc = 32'h608; t.r = 1; t.ec = 2; step(t, 1'b0);
      chk("mrst_count", 32'(count_o), 0);
      chk("mrst_valid", 32'(out_valid_o), 0);
      chk("mrst_ready", 32'(in_ready_o), 1);
      chk("mrst_head_pc", out_pc_o, 0);
      chk("mrst_head_inst", out_inst_o, 0);
      chk("mrst_head_trap", 32'(out_trap_o), 0);
      chk("mrst_head_cmp", 32'(out_cmp_o), 0);
      t.v = 0; t.r = 1; t.ec = 0; step(t, 1'b1);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, 2 to 16.
REQ-002 SHALL have parameter PTR_W, default $clog2(DEPTH), read/write pointer width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1, ifu offers a fetched instruction this cycle.
REQ-006 SHALL have port in_ready_o, output, 1, queue accepts the offered instruction this cycle.
REQ-007 SHALL have port in_pc_i, input, 32, PC of the offered instruction.
REQ-008 SHALL have port in_inst_i, input, 32, instruction word.
REQ-009 SHALL have port in_trap_i, input, TRAP_LEN, trap bus from ifu (page fault and similar).
REQ-010 SHALL have port in_cmp_i, input, 1, instruction is compressed.
REQ-011 SHALL have port out_valid_o, output, 1, head entry is valid for decode.
REQ-012 SHALL have port out_ready_i, input, 1, decode consumes the head this cycle (low while id is stalled).
REQ-013 SHALL have ports out_pc_o (32), out_inst_o (32), out_trap_o (TRAP_LEN), out_cmp_o (1), outputs, head entry fields.
REQ-014 SHALL have port flush_i, input, 1, redirect from exu/trap; discards all entries.
REQ-015 SHALL have port count_o, output, PTR_W+1, current occupancy.

Function
REQ-016 A push SHALL occur exactly when in_valid_i && in_ready_o && !flush_i.
REQ-017 A pop SHALL occur exactly when out_valid_o && out_ready_i && !flush_i.
REQ-018 in_ready_o SHALL equal (count < DEPTH); no write-through when full, even if a pop occurs in the same cycle.
REQ-019 out_valid_o SHALL equal (count != 0); the queue provides no bypass, so an entry pushed in cycle N is visible at the head in cycle N+1.
REQ-020 Head fields SHALL be a combinational read of the storage entry at rd_ptr; their values while out_valid_o is low are don't-care, but SHALL not be X after reset.
REQ-021 On a push, all four fields SHALL be written to the entry at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-022 On a pop, rd_ptr SHALL increment modulo DEPTH.
REQ-023 Count update: push only, +1; pop only, -1; both, unchanged; neither, unchanged.
REQ-024 count SHALL never exceed DEPTH and never underflow; the design SHALL contain an assertion checking this.
REQ-025 Flush SHALL take priority over push and pop: in the flush cycle both are suppressed, and on the next edge rd_ptr, wr_ptr and count SHALL all become 0.
REQ-026 in_ready_o and out_valid_o SHALL be derived from registered count only; they SHALL not depend combinationally on flush_i or on the opposite handshake.
REQ-027 Entries carrying a nonzero in_trap_i SHALL be queued and delivered in order like any other entry; the queue SHALL not interpret trap bits.
REQ-028 Order SHALL be strict FIFO; there SHALL be no reordering and no duplication.

Reset
REQ-029 While rst_n is low at a rising edge: rd_ptr, wr_ptr and count SHALL become 0, so out_valid_o=0, in_ready_o=1 and count_o=0.
REQ-030 Storage entries SHALL be cleared to 0 on reset, making head fields 0 after reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries, taking priority over flush, push and pop.

Structure
REQ-032 TRAP_LEN and TRAP_BUS SHALL come from the shared sysconfig.v include; the entry field layout (a packed 65+TRAP_LEN-bit entry) SHALL be defined as macros in sysconfig.v for reuse by the if/id stage.
REQ-033 The queue SHALL be a single flat module with no sub-modules; storage is a register array indexed by the pointers.

Verification
REQ-034 Reset then push PC 0x80000000, inst 0x00000013 at cycle 1 -> out_valid_o=1 at cycle 2 with the same values; count_o=1.
REQ-035 Push 4 entries with out_ready_i=0 -> in_ready_o=0 and count_o=4; a 5th offer is not accepted; popping 1 -> in_ready_o=1 on the next cycle.
REQ-036 Hold count at 2 and apply push and pop every cycle for 10 cycles (PCs 0x100, 0x104, ...) -> count stays 2, output PCs appear in order, pointers wrap correctly.
REQ-037 At count=3, assert flush_i together with in_valid_i and out_ready_i -> no pop is registered, and next cycle count_o=0, out_valid_o=0; the offered entry is lost.
REQ-038 Push an entry with in_trap_i bit TRAP_INST_PAGE_FAULT set, followed by a normal entry -> both delivered in order with trap bits intact.
REQ-039 Drive rst_n=0 for one cycle at count=2 -> next cycle count_o=0, out_valid_o=0, in_ready_o=1, head fields 0.
